// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder.
// Takes decoded instruction fields and writes the matching fetch-stage byte
// stream, one byte per clock, into a byte-wide instruction memory starting at
// a running write pointer (val_p).
module y86_instr_encoder #(
   parameter int MEM_SIZE = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        set_addr_v,
   input  logic [63:0] set_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_code,
   input  logic [3:0]  in_fun,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [63:0] val_c,
   output logic        mem_wr_en,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic [63:0] val_p,
   output logic        done,
   output logic        flag_halt,
   output logic        in_error,
   output logic        bad_mem
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EMIT   = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   localparam logic [3:0]  ICODE_HALT = 4'd0;
   localparam logic [3:0]  ICODE_MAX  = 4'd11;
   localparam logic [64:0] MEM_LIMIT  = 65'(MEM_SIZE);

   // Encoded length in bytes for each icode; 0 marks an illegal icode.
   function automatic logic [3:0] instr_len(input logic [3:0] code);
      logic [3:0] len;
      case (code)
         4'd0, 4'd1, 4'd9:          len = 4'd1;
         4'd2, 4'd6, 4'd10, 4'd11:  len = 4'd2;
         4'd7, 4'd8:                len = 4'd9;
         4'd3, 4'd4, 4'd5:          len = 4'd10;
         default:                   len = 4'd0;
      endcase
      return len;
   endfunction

   logic [1:0]  state_q,     state_d;
   logic [63:0] val_p_q,     val_p_d;
   logic [3:0]  idx_q,       idx_d;
   logic [3:0]  len_q,       len_d;
   logic [3:0]  code_q,      code_d;
   logic [3:0]  fun_q,       fun_d;
   logic [3:0]  ra_q,        ra_d;
   logic [3:0]  rb_q,        rb_d;
   logic [63:0] valc_q,      valc_d;
   logic        wr_en_q,     wr_en_d;
   logic [63:0] addr_q,      addr_d;
   logic [7:0]  data_q,      data_d;
   logic        done_q,      done_d;
   logic        halt_q,      halt_d;
   logic        err_q,       err_d;
   logic        bad_q,       bad_d;

   // End address (exclusive) of the offered instruction; one extra bit so a
   // pointer near 2^64 cannot wrap past the memory-size check.
   logic [64:0] offer_end;
   assign offer_end = {1'b0, val_p_q} + {61'd0, instr_len(in_code)};

   // Byte image of the latched instruction, indexed by idx_q.
   // Byte 1 is the register pair except for 9-byte forms (jXX/call),
   // where the constant starts immediately after the opcode byte.
   logic [15:0][7:0] byte_arr;
   logic             is_len10;
   assign is_len10 = (len_q == 4'd10);

   assign byte_arr[0] = {code_q, fun_q};
   assign byte_arr[1] = (len_q == 4'd9) ? valc_q[7:0] : {ra_q, rb_q};

   genvar gi;
   generate
      for (gi = 2; gi <= 8; gi++) begin : g_const_bytes
         assign byte_arr[gi] = is_len10 ? valc_q[8*(gi-2) +: 8]
                                        : valc_q[8*(gi-1) +: 8];
      end
   endgenerate

   assign byte_arr[9] = is_len10 ? valc_q[63:56] : 8'h00;

   generate
      for (gi = 10; gi < 16; gi++) begin : g_unused_bytes
         assign byte_arr[gi] = 8'h00;
      end
   endgenerate

   // Handshake is only open in IDLE, and a pointer load takes the cycle.
   assign in_ready = (state_q == S_IDLE) && !set_addr_v;

   // Next-state logic: accept/reject in IDLE, one byte per cycle in EMIT.
   always_comb begin
      state_d = state_q;
      val_p_d = val_p_q;
      idx_d   = idx_q;
      len_d   = len_q;
      code_d  = code_q;
      fun_d   = fun_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      valc_d  = valc_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      halt_d  = halt_q;
      err_d   = err_q;
      bad_d   = bad_q;

      case (state_q)
         S_IDLE: begin
            if (set_addr_v) begin
               val_p_d = set_addr;
            end else if (in_valid) begin
               if (in_code > ICODE_MAX) begin
                  err_d = 1'b1;
               end else if (offer_end > MEM_LIMIT) begin
                  bad_d = 1'b1;
               end else begin
                  code_d  = in_code;
                  fun_d   = in_fun;
                  ra_d    = ra;
                  rb_d    = rb;
                  valc_d  = val_c;
                  len_d   = instr_len(in_code);
                  idx_d   = 4'd0;
                  state_d = S_EMIT;
               end
            end
         end

         S_EMIT: begin
            wr_en_d = 1'b1;
            addr_d  = val_p_q + {60'd0, idx_q};
            data_d  = byte_arr[idx_q];
            idx_d   = idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) begin
               done_d  = 1'b1;
               idx_d   = 4'd0;
               val_p_d = val_p_q + {60'd0, len_q};
               if (code_q == ICODE_HALT) begin
                  halt_d  = 1'b1;
                  state_d = S_HALTED;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_HALTED: begin
            state_d = S_HALTED;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any instruction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         val_p_q <= 64'd0;
         idx_q   <= 4'd0;
         len_q   <= 4'd0;
         code_q  <= 4'd0;
         fun_q   <= 4'd0;
         ra_q    <= 4'd0;
         rb_q    <= 4'd0;
         valc_q  <= 64'd0;
         wr_en_q <= 1'b0;
         addr_q  <= 64'd0;
         data_q  <= 8'd0;
         done_q  <= 1'b0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         val_p_q <= val_p_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         code_q  <= code_d;
         fun_q   <= fun_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         valc_q  <= valc_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
         bad_q   <= bad_d;
      end
   end

   assign mem_wr_en = wr_en_q;
   assign mem_addr  = addr_q;
   assign mem_data  = data_q;
   assign val_p     = val_p_q;
   assign done      = done_q;
   assign flag_halt = halt_q;
   assign in_error  = err_q;
   assign bad_mem   = bad_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: directed cases plus randomized instructions,
// each byte checked against a reference encoding built from the length table
// and byte-layout rules.
module tb_y86_instr_encoder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        set_addr_v;
   logic [63:0] set_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_code;
   logic [3:0]  in_fun;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [63:0] val_c;
   logic        mem_wr_en;
   logic [63:0] mem_addr;
   logic [7:0]  mem_data;
   logic [63:0] val_p;
   logic        done;
   logic        flag_halt;
   logic        in_error;
   logic        bad_mem;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [64:0] m_valp;
   bit          m_halt;
   bit          m_err;
   bit          m_bad;

   y86_instr_encoder #(.MEM_SIZE(1024)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .set_addr_v (set_addr_v),
      .set_addr   (set_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_fun     (in_fun),
      .ra         (ra),
      .rb         (rb),
      .val_c      (val_c),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .val_p      (val_p),
      .done       (done),
      .flag_halt  (flag_halt),
      .in_error   (in_error),
      .bad_mem    (bad_mem)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_len(input int ic);
      case (ic)
         0, 1, 9:       return 1;
         2, 6, 10, 11:  return 2;
         7, 8:          return 9;
         3, 4, 5:       return 10;
         default:       return 0;
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
      chk({tag, "_addr"},  mem_addr, 64'd0);
      chk({tag, "_data"},  64'(mem_data), 64'd0);
      chk({tag, "_done"},  64'(done), 64'd0);
      chk({tag, "_val_p"}, val_p, 64'd0);
      chk({tag, "_halt"},  64'(flag_halt), 64'd0);
      chk({tag, "_err"},   64'(in_error), 64'd0);
      chk({tag, "_bad"},   64'(bad_mem), 64'd0);
   endtask

   task automatic model_reset();
      m_valp = 65'd0;
      m_halt = 0;
      m_err  = 0;
      m_bad  = 0;
   endtask

   // Called shortly after a negedge; pulses reset asynchronously.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs(tag);
      @(negedge clock);
      reset_n    = 1'b1;
      in_valid   = 1'b0;
      set_addr_v = 1'b0;
      #1;
      chk({tag, "_ready"}, 64'(in_ready), 64'd1);
   endtask

   // Load the write pointer while also offering a legal instruction that
   // must not be taken.
   task automatic load_addr(input logic [63:0] a);
      set_addr_v = 1'b1;
      set_addr   = a;
      in_valid   = 1'b1;
      in_code    = 4'd6;
      #1;
      chk("setaddr_ready", 64'(in_ready), 64'd0);
      @(posedge clock);
      @(negedge clock);
      m_valp = {1'b0, a};
      chk("setaddr_val_p", val_p, a);
      chk("setaddr_no_wr", 64'(mem_wr_en), 64'd0);
      set_addr_v = 1'b0;
      in_valid   = 1'b0;
      #1;
   endtask

   // Offer one instruction (caller is just after a negedge) and check every
   // resulting byte. abort_at >= 0 pulses reset after that byte index.
   task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra_v, input logic [3:0] rb_v,
                       input logic [63:0] vc, input int abort_at);
      int len;
      logic [7:0] eb[$];
      len = ref_len(int'(ic));
      eb.push_back({ic, fn});
      if (len == 2 || len == 10) eb.push_back({ra_v, rb_v});
      if (len >= 9) for (int i = 0; i < 8; i++) eb.push_back(vc[8*i +: 8]);

      in_valid = 1'b1;
      in_code  = ic;
      in_fun   = fn;
      ra       = ra_v;
      rb       = rb_v;
      val_c    = vc;
      #1;

      if (m_halt) begin
         chk("halted_ready", 64'(in_ready), 64'd0);
         @(posedge clock);
         @(negedge clock);
         chk("halted_no_wr", 64'(mem_wr_en), 64'd0);
         chk("halted_flag", 64'(flag_halt), 64'd1);
         in_valid = 1'b0;
         #1;
         return;
      end

      chk("offer_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      @(negedge clock);

      if (len == 0) begin
         m_err = 1;
         in_valid = 1'b0;
         #1;
         chk("illegal_no_wr", 64'(mem_wr_en), 64'd0);
         chk("illegal_err", 64'(in_error), 64'd1);
         chk("illegal_val_p", val_p, m_valp[63:0]);
         chk("illegal_ready", 64'(in_ready), 64'd1);
         return;
      end

      if (m_valp + 65'(len) > 65'd1024) begin
         m_bad = 1;
         in_valid = 1'b0;
         #1;
         chk("oob_no_wr", 64'(mem_wr_en), 64'd0);
         chk("oob_bad", 64'(bad_mem), 64'd1);
         chk("oob_val_p", val_p, m_valp[63:0]);
         chk("oob_ready", 64'(in_ready), 64'd1);
         return;
      end

      chk("accept_busy", 64'(in_ready), 64'd0);
      chk("accept_no_wr_yet", 64'(mem_wr_en), 64'd0);

      for (int k = 0; k < len; k++) begin
         // Junk on the inputs while emitting must be ignored.
         in_valid   = 1'($urandom);
         in_code    = 4'($urandom);
         ra         = 4'($urandom);
         val_c      = {$urandom, $urandom};
         set_addr_v = 1'($urandom);
         set_addr   = {$urandom, $urandom};
         @(negedge clock);
         chk($sformatf("byte%0d_wr_en", k), 64'(mem_wr_en), 64'd1);
         chk($sformatf("byte%0d_addr", k), mem_addr, m_valp[63:0] + 64'(k));
         chk($sformatf("byte%0d_data", k), 64'(mem_data), 64'(eb[k]));
         chk($sformatf("byte%0d_done", k), 64'(done), 64'(k == len - 1));
         if (k == abort_at) begin
            do_reset("abort");
            chk("abort_val_p", val_p, 64'd0);
            return;
         end
      end

      m_valp = m_valp + 65'(len);
      if (ic == 4'd0) m_halt = 1;
      in_valid   = 1'b0;
      set_addr_v = 1'b0;
      #1;
      chk("end_val_p", val_p, m_valp[63:0]);
      chk("end_halt", 64'(flag_halt), 64'(m_halt));
      chk("end_ready", 64'(in_ready), 64'(!m_halt));
      chk("end_err", 64'(in_error), 64'(m_err));
      chk("end_bad", 64'(bad_mem), 64'(m_bad));
   endtask

   initial begin
      reset_n    = 1'b1;
      set_addr_v = 1'b0;
      set_addr   = 64'd0;
      in_valid   = 1'b0;
      in_code    = 4'd0;
      in_fun     = 4'd0;
      ra         = 4'd0;
      rb         = 4'd0;
      val_c      = 64'd0;
      model_reset();

      // Power-on reset
      @(negedge clock);
      do_reset("por");

      // irmovq at address 0
      send(4'd3, 4'd0, 4'hF, 4'h2, 64'h0123456789ABCDEF, -1);
      chk("irmovq_val_p", val_p, 64'd10);

      // addq then jmp back to back from address 0
      do_reset("rst2");
      send(4'd6, 4'd0, 4'h1, 4'h2, 64'd0, -1);
      send(4'd7, 4'd0, 4'h0, 4'h0, 64'h40, -1);
      chk("b2b_val_p", val_p, 64'd11);

      // Illegal icode, then a nop still goes through
      send(4'd12, 4'd0, 4'h0, 4'h0, 64'd0, -1);
      send(4'd1, 4'd0, 4'h0, 4'h0, 64'd0, -1);

      // Memory-size boundary
      load_addr(64'd1015);
      send(4'd5, 4'd0, 4'h3, 4'h4, 64'h1122334455667788, -1);
      load_addr(64'd1014);
      send(4'd5, 4'd0, 4'h3, 4'h4, 64'h1122334455667788, -1);
      chk("edge_val_p", val_p, 64'd1024);
      send(4'd1, 4'd0, 4'h0, 4'h0, 64'd0, -1);

      // Reset during byte 4 of rmmovq
      do_reset("rst3");
      send(4'd4, 4'd0, 4'h5, 4'h6, 64'hCAFEBABEDEADBEEF, 4);

      // Randomized instructions, including illegal ones and pointer loads
      for (int n = 0; n < 60; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) load_addr(64'($urandom_range(1000, 1023)));
         else if (r == 1) load_addr(64'($urandom_range(0, 1023)));
         send(4'($urandom_range(1, 13)), 4'($urandom), 4'($urandom), 4'($urandom),
              {$urandom, $urandom}, -1);
      end

      // Halt freezes the encoder until reset
      do_reset("rst4");
      send(4'd0, 4'd0, 4'h0, 4'h0, 64'd0, -1);
      send(4'd1, 4'd0, 4'h0, 4'h0, 64'd0, -1);
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         @(negedge clock);
         chk("frozen_no_wr", 64'(mem_wr_en), 64'd0);
         chk("frozen_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      do_reset("rst5");
      send(4'd1, 4'd0, 4'h0, 4'h0, 64'd0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
